// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the WS2812B frame scheduler:
//   - sched_state_t : scheduler FSM states
//   - grb_t         : one 24-bit GRB colour word, bit 23 sent first
//   - DEF_*         : default WS2812B bit/latch timings in 40 MHz clock cycles
// ---------------------------------------------------------------------------
package led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } sched_state_t;

  typedef logic [23:0] grb_t;

  localparam int GRB_BITS      = 24;
  localparam int DEF_T0H       = 16;
  localparam int DEF_T0L       = 34;
  localparam int DEF_T1H       = 32;
  localparam int DEF_T1L       = 18;
  localparam int DEF_RESET_CYC = 2000;

endpackage

// File: rtl/led_bit_tx.sv
// ---------------------------------------------------------------------------
// led_bit_tx
// Serialises one 24-bit GRB word MSB-first with WS2812B bit timing: each bit
// is TxH cycles high followed by TxL cycles low.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   load           take load_word and start sending it this edge (may coincide
//                  with word_last_low for back-to-back words)
//   load_word      24-bit colour to send
//   word_last_low  high during the last low cycle of the word's final bit
//   dout           serial line
// ---------------------------------------------------------------------------
module led_bit_tx
  import led_pkg::*;
#(
  parameter int T0H = DEF_T0H,
  parameter int T0L = DEF_T0L,
  parameter int T1H = DEF_T1H,
  parameter int T1L = DEF_T1L
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [23:0] load_word,
  output logic        word_last_low,
  output logic        dout
);

  localparam int BIT0_LEN = T0H + T0L;
  localparam int BIT1_LEN = T1H + T1L;
  localparam int MAX_LEN  = (BIT0_LEN > BIT1_LEN) ? BIT0_LEN : BIT1_LEN;
  localparam int PH_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  grb_t            shift_q, shift_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [4:0]      bit_q, bit_d;
  logic            active_q, active_d;

  logic            cur_bit;
  logic [PH_W-1:0] high_len;
  logic [PH_W-1:0] last_phase;
  logic            bit_end;

  always_comb begin
    cur_bit       = shift_q[GRB_BITS-1];
    high_len      = cur_bit ? PH_W'(T1H) : PH_W'(T0H);
    last_phase    = cur_bit ? PH_W'(BIT1_LEN - 1) : PH_W'(BIT0_LEN - 1);
    bit_end       = active_q && (phase_q == last_phase);
    word_last_low = bit_end && (bit_q == 5'(GRB_BITS - 1));
    // Line level is a single compare on flopped state, so it is low the
    // cycle after reset and during every idle/fetch/latch cycle.
    dout          = active_q && (phase_q < high_len);

    shift_d  = shift_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    active_d = active_q;

    if (load) begin
      shift_d  = load_word;
      phase_d  = '0;
      bit_d    = '0;
      active_d = 1'b1;
    end else if (bit_end) begin
      phase_d = '0;
      if (word_last_low) begin
        bit_d    = '0;
        active_d = 1'b0;
      end else begin
        shift_d = {shift_q[GRB_BITS-2:0], 1'b0};
        bit_d   = bit_q + 5'd1;
      end
    end else if (active_q) begin
      phase_d = phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_q  <= '0;
      phase_q  <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/led_frame_scheduler.sv
// ---------------------------------------------------------------------------
// led_frame_scheduler
// Frame controller for a WS2812B matrix: walks every LED in chain order,
// fetches its GRB colour from a row-major frame buffer (one pixel prefetched
// ahead), serialises it through led_bit_tx, then holds the latch gap.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   start         1-cycle pulse, send one frame (ignored while busy)
//   busy          high from the cycle after an accepted start until frame_done
//   frame_done    1-cycle pulse in the last latch-gap cycle
//   pix_req       fetch request, pix_addr stable while high
//   pix_addr      frame-buffer address row*NUM_COLS + col
//   pix_ack       1-cycle acknowledge, pix_data valid with it
//   pix_data      GRB colour
//   datastream    WS2812B serial line
// Configuration macro: LED_SERPENTINE_EN
//   defined   : odd columns are wired bottom-up (snake wiring)
//   undefined : every column wired top-down
// ---------------------------------------------------------------------------
module led_frame_scheduler
  import led_pkg::*;
#(
  parameter int NUM_COLS  = 8,
  parameter int NUM_ROWS  = 8,
  parameter int ADDR_W    = 6,
  parameter int T0H       = DEF_T0H,
  parameter int T0L       = DEF_T0L,
  parameter int T1H       = DEF_T1H,
  parameter int T1L       = DEF_T1L,
  parameter int RESET_CYC = DEF_RESET_CYC
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic              pix_req,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic              pix_ack,
  input  logic [23:0]       pix_data,
  output logic              datastream
);

  localparam int NUM_LEDS = NUM_COLS * NUM_ROWS;
  localparam int IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int LAT_W    = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
  localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(RESET_CYC - 1);

  // Chain index -> frame-buffer address. The chain runs down each column.
  function automatic logic [ADDR_W-1:0] led_addr(input logic [IDX_W-1:0] idx);
    int col;
    int p;
    int row;
    col = int'(idx) / NUM_ROWS;
    p   = int'(idx) % NUM_ROWS;
`ifdef LED_SERPENTINE_EN
    row = (col % 2 == 1) ? (NUM_ROWS - 1 - p) : p;
`else
    row = p;
`endif
    return ADDR_W'(row * NUM_COLS + col);
  endfunction

  sched_state_t      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  grb_t              buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic [LAT_W-1:0]  lat_q, lat_d;

  logic              tx_load;
  logic [23:0]       tx_word;
  logic              word_last_low;
  logic              ack_ok;
  logic              has_next;

  assign ack_ok   = req_q && pix_ack;     // acks with no request are ignored
  assign has_next = (idx_q != LAST_IDX);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    req_d      = req_q;
    addr_d     = addr_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    lat_d      = lat_q;
    tx_load    = 1'b0;
    tx_word    = buf_q;
    frame_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          idx_d   = '0;
          req_d   = 1'b1;
          addr_d  = led_addr('0);
        end
      end

      FETCH: begin
        if (ack_ok) begin
          tx_load = 1'b1;
          tx_word = pix_data;
          req_d   = 1'b0;
          state_d = SEND;
        end
      end

      SEND: begin
        // Prefetch: one outstanding request for idx+1 while the buffer is empty.
        if (ack_ok) begin
          buf_d      = pix_data;
          buf_full_d = 1'b1;
          req_d      = 1'b0;
        end else if (!req_q && !buf_full_q && has_next && !word_last_low) begin
          req_d  = 1'b1;
          addr_d = led_addr(idx_q + 1'b1);
        end

        if (word_last_low) begin
          if (!has_next) begin
            state_d = LATCH;
            lat_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
            if (buf_full_q) begin
              tx_load    = 1'b1;
              tx_word    = buf_q;
              buf_full_d = 1'b0;
            end else if (ack_ok) begin
              // Prefetch data landing on the word boundary goes straight out.
              tx_load    = 1'b1;
              tx_word    = pix_data;
              buf_full_d = 1'b0;
            end else if (req_q) begin
              // Keep the pending request as is; FETCH waits for its ack.
              state_d = FETCH;
            end else begin
              state_d = FETCH;
              req_d   = 1'b1;
              addr_d  = led_addr(idx_q + 1'b1);
            end
          end
        end
      end

      LATCH: begin
        if (lat_q == LAT_END) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      lat_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      lat_q      <= lat_d;
    end
  end

  assign busy     = (state_q != IDLE) && !frame_done;
  assign pix_req  = req_q;
  assign pix_addr = addr_q;

  led_bit_tx #(
    .T0H(T0H),
    .T0L(T0L),
    .T1H(T1H),
    .T1L(T1L)
  ) u_bit_tx (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (tx_load),
    .load_word    (tx_word),
    .word_last_low(word_last_low),
    .dout         (datastream)
  );

endmodule

// File: tb/tb_led_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_led_frame_scheduler
// Directed bench for led_frame_scheduler on an 8x8 matrix with shortened bit
// and latch timings. A frame-buffer model answers requests with a chosen
// latency; monitors record pulse widths, frame_done pulses and requests.
// ---------------------------------------------------------------------------
module tb_led_frame_scheduler;

  localparam int NUM_COLS  = 8;
  localparam int NUM_ROWS  = 8;
  localparam int NUM_LEDS  = 64;
  localparam int ADDR_W    = 6;
  localparam int T0H       = 2;
  localparam int T0L       = 3;
  localparam int T1H       = 3;
  localparam int T1L       = 2;
  localparam int RESET_CYC = 200;
  localparam int FRAME_PULSES = 1536;
  localparam int MAXP = 16384;
  localparam int MAXR = 1024;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              busy;
  logic              frame_done;
  logic              pix_req;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_ack;
  logic [23:0]       pix_data;
  logic              datastream;

  led_frame_scheduler #(
    .NUM_COLS(NUM_COLS), .NUM_ROWS(NUM_ROWS), .ADDR_W(ADDR_W),
    .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L), .RESET_CYC(RESET_CYC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy),
    .frame_done(frame_done), .pix_req(pix_req), .pix_addr(pix_addr),
    .pix_ack(pix_ack), .pix_data(pix_data), .datastream(datastream)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int ack_lat  = 1;
  int pix_mode = 0;

  // ------------------------------------------------------------- reference
  function automatic int exp_addr(input int i);
    int col;
    int p;
    int row;
    col = i / NUM_ROWS;
    p   = i % NUM_ROWS;
`ifdef LED_SERPENTINE_EN
    row = (col % 2 == 1) ? (NUM_ROWS - 1 - p) : p;
`else
    row = p;
`endif
    return row * NUM_COLS + col;
  endfunction

  function automatic logic [23:0] exp_color(input int mode, input int addr);
    logic [5:0] a;
    a = 6'(addr);
    if (mode == 0) return 24'hFFFFFF;
    if (mode == 1) return (addr == 0) ? 24'h800000 : 24'h000000;
    return {2'b01, a, 8'hC3, 2'b10, ~a};
  endfunction

  // ------------------------------------------------------ frame-buffer model
  initial begin : fb_model
    int wait_cnt;
    wait_cnt = 0;
    pix_ack  = 1'b0;
    pix_data = '0;
    forever begin
      @(negedge clk);
      pix_ack = 1'b0;
      if (pix_req === 1'b1 && reset_n === 1'b1) begin
        wait_cnt++;
        if (wait_cnt >= ack_lat) begin
          pix_ack  = 1'b1;
          pix_data = exp_color(pix_mode, int'(pix_addr));
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ------------------------------------------------------------ line monitor
  int   hi_w[MAXP];
  int   lo_w[MAXP];
  int   npulse = 0;
  int   run = 0;
  logic prev_ds = 1'b0;
  int   fd_count = 0;
  int   last_done_low = 0;

  initial begin : line_mon
    forever begin
      @(negedge clk);
      if (datastream === prev_ds) begin
        run++;
      end else begin
        if (prev_ds) begin
          if (npulse > 0 && npulse <= MAXP) hi_w[npulse-1] = run;
        end else begin
          if (npulse > 0 && npulse <= MAXP) lo_w[npulse-1] = run;
          npulse++;
        end
        run     = 1;
        prev_ds = datastream;
      end
      if (frame_done === 1'b1) begin
        fd_count++;
        last_done_low = (datastream === 1'b0) ? run : 0;
      end
    end
  end

  // --------------------------------------------------------- request monitor
  int                req_log[MAXR];
  int                nreq = 0;
  int                addr_unstable = 0;
  logic              prev_req = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  initial begin : req_mon
    forever begin
      @(negedge clk);
      if (pix_req === 1'b1) begin
        if (prev_req && pix_addr !== prev_addr) addr_unstable++;
        if (!prev_req) begin
          if (nreq < MAXR) req_log[nreq] = int'(pix_addr);
          nreq++;
        end
      end
      prev_req  = (pix_req === 1'b1);
      prev_addr = pix_addr;
    end
  end

  // ------------------------------------------------------------- analysis
  function automatic int count_bad_pulses(input int base, input int mode, input bit gaps);
    int         nbad;
    int         pix;
    int         b;
    logic [23:0] c;
    logic       bv;
    nbad = 0;
    for (int k = 0; k < FRAME_PULSES; k++) begin
      if (base + k >= MAXP) return nbad + 1;
      pix = k / 24;
      b   = 23 - (k % 24);
      c   = exp_color(mode, exp_addr(pix));
      bv  = c[b];
      if (hi_w[base+k] != (bv ? T1H : T0H)) nbad++;
      if (k != FRAME_PULSES - 1 && !(gaps && (k % 24 == 23)))
        if (lo_w[base+k] != (bv ? T1L : T0L)) nbad++;
    end
    return nbad;
  endfunction

  function automatic int count_bad_reqs(input int base);
    int nbad;
    nbad = 0;
    for (int i = 0; i < NUM_LEDS; i++)
      if (base + i >= MAXR || req_log[base+i] != exp_addr(i)) nbad++;
    return nbad;
  endfunction

  // -------------------------------------------------------------- stimulus
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_frame_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  int t1_req_base = 0;
  int f5_base = 0;

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    reset_n = 1'b0;
    cycles(3);
    total++; if (datastream !== 1'b0) begin bad++; $display("FAIL reset_datastream got=%b want=0", datastream); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    total++; if (pix_req !== 1'b0) begin bad++; $display("FAIL reset_pix_req got=%b want=0", pix_req); end
    total++; if (pix_addr !== 6'd0) begin bad++; $display("FAIL reset_pix_addr got=%0d want=0", pix_addr); end
    reset_n = 1'b1;
    cycles(3);
    total++; if (busy !== 1'b0 || pix_req !== 1'b0) begin bad++; $display("FAIL idle_no_start got busy=%b req=%b want 0/0", busy, pix_req); end
    $display("test_reset done");
  endtask

  task automatic test_all_ones();
    int base_p, base_r, base_fd, unst0;
    bit got;
    pix_mode = 0; ack_lat = 1;
    base_p = npulse; base_r = nreq; base_fd = fd_count; unst0 = addr_unstable;
    pulse_start();
    total++; if (busy !== 1'b1 || pix_req !== 1'b1 || pix_addr !== 6'd0) begin bad++; $display("FAIL ones_first_req got busy=%b req=%b addr=%0d want 1/1/0", busy, pix_req, pix_addr); end
    wait_frame_done(20000, got);
    total++; if (!got) begin bad++; $display("FAIL ones_frame_done got=timeout want=pulse"); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ones_busy_at_done got=%b want=0", busy); end
    cycles(2);
    total++; if (npulse - base_p != 1536) begin bad++; $display("FAIL ones_pulse_count got=%0d want=1536", npulse - base_p); end
    total++; if (count_bad_pulses(base_p, 0, 1'b0) != 0) begin bad++; $display("FAIL ones_pulse_widths got=%0d bad widths want=0", count_bad_pulses(base_p, 0, 1'b0)); end
    total++; if (last_done_low != 202) begin bad++; $display("FAIL ones_latch_low got=%0d want=202", last_done_low); end
    total++; if (fd_count - base_fd != 1) begin bad++; $display("FAIL ones_done_count got=%0d want=1", fd_count - base_fd); end
    total++; if (nreq - base_r != 64) begin bad++; $display("FAIL ones_req_count got=%0d want=64", nreq - base_r); end
    total++; if (count_bad_reqs(base_r) != 0) begin bad++; $display("FAIL ones_req_order got=%0d wrong want=0", count_bad_reqs(base_r)); end
    total++; if (addr_unstable != unst0) begin bad++; $display("FAIL ones_addr_stable got=%0d changes want=0", addr_unstable - unst0); end
    t1_req_base = base_r;
    $display("test_all_ones done pulses=%0d reqs=%0d", npulse - base_p, nreq - base_r);
  endtask

  task automatic test_addr_order();
    int b;
    int want8, want9, want15, want63;
    b = t1_req_base;
`ifdef LED_SERPENTINE_EN
    want8 = 57; want9 = 49; want15 = 1; want63 = 7;
`else
    want8 = 1; want9 = 9; want15 = 57; want63 = 63;
`endif
    total++; if (req_log[b+1] != 8) begin bad++; $display("FAIL order_idx1 got=%0d want=8", req_log[b+1]); end
    total++; if (req_log[b+7] != 56) begin bad++; $display("FAIL order_idx7 got=%0d want=56", req_log[b+7]); end
    total++; if (req_log[b+8] != want8) begin bad++; $display("FAIL order_idx8 got=%0d want=%0d", req_log[b+8], want8); end
    total++; if (req_log[b+9] != want9) begin bad++; $display("FAIL order_idx9 got=%0d want=%0d", req_log[b+9], want9); end
    total++; if (req_log[b+15] != want15) begin bad++; $display("FAIL order_idx15 got=%0d want=%0d", req_log[b+15], want15); end
    total++; if (req_log[b+63] != want63) begin bad++; $display("FAIL order_idx63 got=%0d want=%0d", req_log[b+63], want63); end
    $display("test_addr_order done");
  endtask

  task automatic test_single_one();
    int base_p, base_fd;
    bit got;
    pix_mode = 1; ack_lat = 3;
    base_p = npulse; base_fd = fd_count;
    pulse_start();
    wait_frame_done(20000, got);
    total++; if (!got) begin bad++; $display("FAIL one_frame_done got=timeout want=pulse"); end
    cycles(2);
    total++; if (hi_w[base_p] != 3 || lo_w[base_p] != 2) begin bad++; $display("FAIL one_first_pulse got=%0d/%0d want=3/2", hi_w[base_p], lo_w[base_p]); end
    total++; if (hi_w[base_p+1] != 2 || lo_w[base_p+1] != 3) begin bad++; $display("FAIL one_second_pulse got=%0d/%0d want=2/3", hi_w[base_p+1], lo_w[base_p+1]); end
    total++; if (hi_w[base_p+23] != 2 || lo_w[base_p+23] != 3) begin bad++; $display("FAIL one_pulse23 got=%0d/%0d want=2/3", hi_w[base_p+23], lo_w[base_p+23]); end
    total++; if (npulse - base_p != 1536) begin bad++; $display("FAIL one_pulse_count got=%0d want=1536", npulse - base_p); end
    total++; if (count_bad_pulses(base_p, 1, 1'b0) != 0) begin bad++; $display("FAIL one_pulse_widths got=%0d bad widths want=0", count_bad_pulses(base_p, 1, 1'b0)); end
    total++; if (last_done_low != 203) begin bad++; $display("FAIL one_latch_low got=%0d want=203", last_done_low); end
    total++; if (fd_count - base_fd != 1) begin bad++; $display("FAIL one_done_count got=%0d want=1", fd_count - base_fd); end
    $display("test_single_one done");
  endtask

  task automatic test_slow_ack();
    int base_p, base_r, base_fd, unst0;
    bit got;
    pix_mode = 2; ack_lat = 130;
    base_p = npulse; base_r = nreq; base_fd = fd_count; unst0 = addr_unstable;
    pulse_start();
    wait_frame_done(30000, got);
    total++; if (!got) begin bad++; $display("FAIL slow_frame_done got=timeout want=pulse"); end
    cycles(2);
    total++; if (npulse - base_p != 1536) begin bad++; $display("FAIL slow_pulse_count got=%0d want=1536", npulse - base_p); end
    total++; if (count_bad_pulses(base_p, 2, 1'b1) != 0) begin bad++; $display("FAIL slow_pulse_data got=%0d bad widths want=0", count_bad_pulses(base_p, 2, 1'b1)); end
    total++; if (lo_w[base_p+23] <= T0L) begin bad++; $display("FAIL slow_fetch_gap got=%0d want>%0d", lo_w[base_p+23], T0L); end
    total++; if (addr_unstable != unst0) begin bad++; $display("FAIL slow_addr_stable got=%0d changes want=0", addr_unstable - unst0); end
    total++; if (nreq - base_r != 64) begin bad++; $display("FAIL slow_req_count got=%0d want=64", nreq - base_r); end
    total++; if (count_bad_reqs(base_r) != 0) begin bad++; $display("FAIL slow_req_order got=%0d wrong want=0", count_bad_reqs(base_r)); end
    total++; if (fd_count - base_fd != 1) begin bad++; $display("FAIL slow_done_count got=%0d want=1", fd_count - base_fd); end
    $display("test_slow_ack done");
  endtask

  task automatic test_start_ignore();
    int base_p, base_r, base_fd;
    bit got;
    pix_mode = 0; ack_lat = 1;
    base_p = npulse; base_r = nreq; base_fd = fd_count;
    pulse_start();
    cycles(300);
    pulse_start();
    wait_frame_done(20000, got);
    total++; if (!got) begin bad++; $display("FAIL ign_frame_done got=timeout want=pulse"); end
    total++; if (npulse - base_p != 1536) begin bad++; $display("FAIL ign_pulse_count got=%0d want=1536", npulse - base_p); end
    total++; if (nreq - base_r != 64) begin bad++; $display("FAIL ign_req_count got=%0d want=64", nreq - base_r); end
    f5_base = npulse;
    start = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || pix_req !== 1'b0) begin bad++; $display("FAIL ign_start_at_done got busy=%b req=%b want 0/0", busy, pix_req); end
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1 || pix_req !== 1'b1 || pix_addr !== 6'd0) begin bad++; $display("FAIL ign_restart got busy=%b req=%b addr=%0d want 1/1/0", busy, pix_req, pix_addr); end
    cycles(2);
    total++; if (fd_count - base_fd != 1) begin bad++; $display("FAIL ign_done_count got=%0d want=1", fd_count - base_fd); end
    $display("test_start_ignore done");
  endtask

  task automatic test_reset_mid();
    int base_p, base_r, base_fd;
    bit hit;
    bit got;
    hit = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (npulse - f5_base >= 245 && datastream === 1'b1) begin
        hit = 1'b1;
        break;
      end
    end
    total++; if (!hit) begin bad++; $display("FAIL mid_reach_pixel10 got=timeout want=pixel 10 high"); end
    base_fd = fd_count;
    reset_n = 1'b0;
    @(negedge clk);
    total++; if (datastream !== 1'b0 || pix_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_abort got ds=%b req=%b busy=%b want 0/0/0", datastream, pix_req, busy); end
    cycles(2);
    reset_n = 1'b1;
    cycles(300);
    total++; if (fd_count != base_fd || busy !== 1'b0) begin bad++; $display("FAIL mid_no_done got dones=%0d busy=%b want 0/0", fd_count - base_fd, busy); end
    pix_mode = 2; ack_lat = 1;
    base_p = npulse; base_r = nreq; base_fd = fd_count;
    pulse_start();
    total++; if (pix_addr !== 6'd0 || busy !== 1'b1) begin bad++; $display("FAIL mid_fresh_start got addr=%0d busy=%b want 0/1", pix_addr, busy); end
    wait_frame_done(20000, got);
    total++; if (!got) begin bad++; $display("FAIL mid_frame_done got=timeout want=pulse"); end
    cycles(2);
    total++; if (npulse - base_p != 1536) begin bad++; $display("FAIL mid_pulse_count got=%0d want=1536", npulse - base_p); end
    total++; if (count_bad_pulses(base_p, 2, 1'b0) != 0) begin bad++; $display("FAIL mid_pulse_data got=%0d bad widths want=0", count_bad_pulses(base_p, 2, 1'b0)); end
    total++; if (count_bad_reqs(base_r) != 0 || nreq - base_r != 64) begin bad++; $display("FAIL mid_req_order got=%0d wrong of %0d want=0 of 64", count_bad_reqs(base_r), nreq - base_r); end
    total++; if (fd_count - base_fd != 1) begin bad++; $display("FAIL mid_done_count got=%0d want=1", fd_count - base_fd); end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_addr_order();
    test_single_one();
    test_slow_ack();
    test_start_ignore();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
